// File: rtl/arm_pkg.sv
// Shared fetch-path constants, counter sizing helper and fetch FSM state type.
package arm_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int INSTR_W_DEF = 32;
  localparam int PC_STEP     = 4;

  // Width of a counter that must hold every value from 0 up to and including depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // RUN: responses are live. DRAIN: stale responses from before a branch are still due.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_queue_fifo.sv
// Synchronous FIFO with push/pop/flush and full/empty/count status.
// Pushing into a full FIFO is accepted only when a pop frees a slot the same cycle.
module if_queue_fifo
  import arm_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  input  logic                      flush,
  output logic [WIDTH-1:0]          pop_data,
  output logic                      full,
  output logic                      empty,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem[rd_ptr_q];

  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  // Next pointer/count; flush returns the FIFO to empty regardless of push/pop.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; count_q==0 already marks every slot invalid.
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: issues in-order imem reads at the current PC, tags each with PC+4,
// buffers responses for decode and freezes the PC whenever no request fires. A taken branch
// flushes the queue and drops every response still in flight before fetching resumes.
module if_fetch_queue
  import arm_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = INSTR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              branch_taken,
  output logic              pc_hold,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_instr
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam int Q_W   = ADDR_W + DATA_W;

  fetch_state_e     state_q, state_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // The tag FIFO holds one entry per request in flight, so its count is the outstanding count.
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  q_count;
  logic [CNT_W:0]    inflight;
  logic [ADDR_W-1:0] tag_head;
  logic [Q_W-1:0]    q_head;
  logic              tag_full, tag_empty, q_full, q_empty;
  logic              fire, rsp_valid, q_push, q_pop;

  assign inflight  = {1'b0, q_count} + {1'b0, outstanding};
  assign imem_req  = !rst && !branch_taken && (state_q == ST_RUN)
                     && (inflight < (CNT_W + 1)'(DEPTH));
  assign imem_addr = pc;
  assign fire      = imem_req && imem_ready;
  assign pc_hold   = !fire;

  // Responses with nothing outstanding are ignored.
  assign rsp_valid = imem_rvalid && !tag_empty;
  assign q_push    = rsp_valid && (state_q == ST_RUN) && !branch_taken;
  assign q_pop     = id_valid && id_ready && !branch_taken;

  assign id_valid  = !q_empty;
  assign id_pc     = id_valid ? q_head[Q_W-1 -: ADDR_W] : '0;
  assign id_instr  = id_valid ? q_head[DATA_W-1:0]     : '0;

  if_queue_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fire),
    .push_data (pc + ADDR_W'(PC_STEP)),
    .pop       (rsp_valid),
    .flush     (1'b0),
    .pop_data  (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (outstanding)
  );

  if_queue_fifo #(.WIDTH(Q_W), .DEPTH(DEPTH)) u_instr_q (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data ({tag_head, imem_rdata}),
    .pop       (q_pop),
    .flush     (branch_taken),
    .pop_data  (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  // Drop counter and RUN/DRAIN next state; a flush counts every response still due as stale.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (branch_taken) begin
      drop_cnt_d = outstanding - CNT_W'(rsp_valid);
    end else if (rsp_valid && (state_q == ST_DRAIN)) begin
      drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end
    state_d = (drop_cnt_d != '0) ? ST_DRAIN : ST_RUN;
  end

  // FSM state and drop counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  a_rsp_without_req: assert property (@(posedge clk) disable iff (rst) imem_rvalid |-> !tag_empty);
  a_tag_overflow:    assert property (@(posedge clk) disable iff (rst) !(fire && tag_full));
  a_q_overflow:      assert property (@(posedge clk) disable iff (rst) !(q_push && q_full && !q_pop));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: models the PC register and a fixed-latency in-order imem.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        branch_taken = 1'b0;
  logic        pc_hold;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  if_fetch_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .branch_taken (branch_taken),
    .pc_hold      (pc_hold),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_pc        (id_pc),
    .id_instr     (id_instr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int          cyc = 0;
  int          lat = 1;
  logic [31:0] branch_addr = '0;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_instr[$];

  logic        s_req, s_hold, s_fire, s_idv;
  logic [31:0] s_addr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  // One clock cycle: called just after a rising edge with inputs set; samples before the next edge,
  // then advances the memory model, the PC register model and the decode log.
  task automatic step();
    logic rv, deq;
    if (mq_due.size() > 0 && mq_due[0] == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(mq_addr[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    #2;
    s_req  = imem_req;
    s_addr = imem_addr;
    s_hold = pc_hold;
    s_fire = imem_req && imem_ready;
    s_idv  = id_valid;
    rv     = imem_rvalid;
    deq    = id_valid && id_ready && !branch_taken;
    if (deq) begin
      got_pc.push_back(id_pc);
      got_instr.push_back(id_instr);
    end
    @(posedge clk);
    #1;
    if (rv) begin
      mq_due.delete(0);
      mq_addr.delete(0);
    end
    if (s_fire) begin
      mq_addr.push_back(s_addr);
      mq_due.push_back(cyc + lat);
    end
    if (branch_taken) pc = branch_addr;
    else if (!s_hold) pc = pc + 32'd4;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    branch_taken = 1'b0;
    imem_ready = 1'b0;
    id_ready = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    pc = '0;
    mq_addr.delete();
    mq_due.delete();
    got_pc.delete();
    got_instr.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  // Decoded stream must be base+4, base+8, ... with the instruction fetched at base, base+4, ...
  task automatic check_stream(input string tag, input logic [31:0] base, input int n);
    check({tag, "_len"}, 64'(got_pc.size() >= n), 64'd1);
    for (int i = 0; i < n && i < got_pc.size(); i++) begin
      check({tag, "_pc"}, got_pc[i], base + 32'(4 * i) + 32'd4);
      check({tag, "_instr"}, got_instr[i], instr_of(base + 32'(4 * i)));
    end
  endtask

  initial begin
    int holds, idv_cnt, n_before;

    // Reset state
    #3;
    check("rst_imem_req", imem_req, 0);
    check("rst_pc_hold", pc_hold, 1);
    check("rst_id_valid", id_valid, 0);
    check("rst_id_pc", id_pc, 0);
    check("rst_id_instr", id_instr, 0);

    // 1. Streaming, 1-cycle latency
    do_reset();
    lat = 1; imem_ready = 1'b1; id_ready = 1'b1;
    holds = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      holds += int'(s_hold);
    end
    check("t1_no_hold", holds, 0);
    check_stream("t1", 32'h0, 10);

    // 2. Decode stall fills the queue, then drains in order
    id_ready = 1'b0;
    n_before = got_pc.size();
    for (int i = 0; i < 10; i++) step();
    check("t2_req_full", s_req, 0);
    check("t2_hold_full", s_hold, 1);
    check("t2_valid_held", s_idv, 1);
    check("t2_no_deq", got_pc.size(), n_before);
    check("t2_pc_stop", pc, 32'(4 * (n_before + 4)));
    id_ready = 1'b1;
    for (int i = 0; i < 15; i++) step();
    check_stream("t2", 32'h0, 20);

    // 3. Branch with two responses in flight, 3-cycle latency
    do_reset();
    lat = 3; imem_ready = 1'b1; id_ready = 1'b1;
    step();
    step();
    imem_ready = 1'b0; branch_taken = 1'b1; branch_addr = 32'h100;
    step();
    check("t3_req_on_branch", s_req, 0);
    branch_taken = 1'b0; imem_ready = 1'b1;
    step();
    check("t3_drain1_req", s_req, 0);
    check("t3_drain1_hold", s_hold, 1);
    step();
    check("t3_drain2_req", s_req, 0);
    step();
    check("t3_resume_req", s_req, 1);
    check("t3_resume_addr", s_addr, 32'h100);
    idv_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      idv_cnt += int'(s_idv);
    end
    check("t3_no_stale_valid", idv_cnt, 0);
    for (int i = 0; i < 8; i++) step();
    check_stream("t3", 32'h100, 4);

    // 4. Branch in the same cycle as the only outstanding response
    do_reset();
    lat = 2; imem_ready = 1'b1; id_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    step();
    imem_ready = 1'b1; branch_taken = 1'b1; branch_addr = 32'h200;
    step();
    check("t4_req_on_branch", s_req, 0);
    branch_taken = 1'b0;
    step();
    check("t4_next_req", s_req, 1);
    check("t4_next_addr", s_addr, 32'h200);
    for (int i = 0; i < 6; i++) step();
    check_stream("t4", 32'h200, 3);

    // 5. imem_ready toggling
    do_reset();
    lat = 1; id_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      imem_ready = (i % 2 == 0);
      step();
      check("t5_req", s_req, 1);
      check("t5_hold", s_hold, 64'(i % 2));
    end
    check("t5_pc", pc, 32'd16);
    imem_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check_stream("t5", 32'h0, 6);

    // 6. Asynchronous reset with three entries queued
    do_reset();
    lat = 1; id_ready = 1'b0; imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    imem_ready = 1'b0;
    step();
    #3;
    check("t6_pre_valid", id_valid, 1);
    check("t6_pre_pc", id_pc, 32'd4);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", id_valid, 0);
    check("t6_rst_pc", id_pc, 0);
    check("t6_rst_instr", id_instr, 0);
    check("t6_rst_req", imem_req, 0);
    check("t6_rst_hold", pc_hold, 1);
    do_reset();
    lat = 1; id_ready = 1'b1; imem_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check_stream("t6", 32'h0, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
